multicycle_controller: RTL and testbench

// - Multicycle successor to the single-cycle control unit: FSM-sequenced control for the 17-bit ISA core.
// - Decodes the top six instruction bits (type/funct/cond), holds the NZCV flag register and evaluates branch conditions.
// - Stalls on a memory ready handshake; sits between the IR/flags of the datapath and every datapath mux/enable.

---
 rtl/multicycle_controller_pkg.sv | 45 ++++
 rtl/multicycle_controller_cond_check.sv | 27 ++
 rtl/multicycle_controller.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states, datapath mux codes,
// instruction-type and branch-condition codes.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXEC_R  = 4'd2,
    EXEC_I  = 4'd3,
    ALU_WB  = 4'd4,
    MEM_ADR = 4'd5,
    MEM_RD  = 4'd6,
    MEM_WB  = 4'd7,
    MEM_WR  = 4'd8,
    BRANCH  = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALU     = 2'b00;
  localparam logic [1:0] RES_ALU_REG = 2'b01;
  localparam logic [1:0] RES_MEM     = 2'b10;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_ONE = 2'b10;

  localparam logic [1:0] TYPE_DATA    = 2'b00;
  localparam logic [1:0] TYPE_MEM     = 2'b01;
  localparam logic [1:0] TYPE_BRANCH  = 2'b10;
  localparam logic [1:0] TYPE_ILLEGAL = 2'b11;

  localparam logic [2:0] COND_EQ = 3'b000;
  localparam logic [2:0] COND_NE = 3'b001;
  localparam logic [2:0] COND_LT = 3'b010;
  localparam logic [2:0] COND_GE = 3'b011;
  localparam logic [2:0] COND_GT = 3'b100;
  localparam logic [2:0] COND_LE = 3'b101;
  localparam logic [2:0] COND_CS = 3'b110;
  localparam logic [2:0] COND_AL = 3'b111;

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// Branch condition evaluator: 3-bit condition code against registered NZCV flags.
module cond_check
  import mc_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       condpass
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    condpass = 1'b0;
    unique case (cond)
      COND_EQ: condpass = z;
      COND_NE: condpass = ~z;
      COND_LT: condpass = n ^ v;
      COND_GE: condpass = ~(n ^ v);
      COND_GT: condpass = ~z & ~(n ^ v);
      COND_LE: condpass = z | (n ^ v);
      COND_CS: condpass = c;
      COND_AL: condpass = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// FSM-sequenced control unit for the 17-bit ISA core: instruction decode, NZCV flag register,
// branch evaluation and memory-ready stalling.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int unsigned INSTR_W = 17,
  parameter int unsigned FLAG_W  = 4,
  parameter int unsigned MEM_HS  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic [FLAG_W-1:0]  ALUFlags,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic [1:0]         RegSrc,
  output logic [1:0]         ImmSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUControl,
  output logic [1:0]         ResultSrc,
  output logic [FLAG_W-1:0]  Flags,
  output logic               illegal,
  output logic [3:0]         state_o
);

  logic [5:0] f;
  logic [1:0] itype;
  logic       i_bit, s_bit, is_ldr;
  logic [1:0] op;
  logic [2:0] cond;
  logic       ready;
  logic       condpass;
  logic       unused_instr;

  assign f      = instr[INSTR_W-1 -: 6];
  assign itype  = f[5:4];
  assign i_bit  = f[3];
  assign op     = f[2:1];
  assign s_bit  = f[0];
  assign is_ldr = f[1];
  assign cond   = f[2:0];
  assign ready  = (MEM_HS != 0) ? mem_ready : 1'b1;

  assign unused_instr = ^instr[INSTR_W-7:0];

  state_t             state_q, state_d;
  logic [FLAG_W-1:0]  flags_q, flags_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  cond_check u_cond_check (
    .cond     (cond),
    .flags    (flags_q[3:0]),
    .condpass (condpass)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (ready) state_d = DECODE;
      DECODE: begin
        unique case (itype)
          TYPE_DATA:   state_d = i_bit ? EXEC_I : EXEC_R;
          TYPE_MEM:    state_d = MEM_ADR;
          TYPE_BRANCH: state_d = BRANCH;
          default:     state_d = FETCH;
        endcase
      end
      EXEC_R:  state_d = ALU_WB;
      EXEC_I:  state_d = ALU_WB;
      ALU_WB:  state_d = FETCH;
      MEM_ADR: state_d = is_ldr ? MEM_RD : MEM_WR;
      MEM_RD:  if (ready) state_d = MEM_WB;
      MEM_WB:  state_d = FETCH;
      MEM_WR:  if (ready) state_d = FETCH;
      BRANCH:  state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Flags only load on leaving an execute state, so BRANCH always sees settled values.
  always_comb begin
    flags_d = flags_q;
    if ((state_q == EXEC_R || state_q == EXEC_I) && s_bit) flags_d = ALUFlags;
  end

  logic pc_write_raw, ir_write_raw, mem_read_raw, mem_write_raw, reg_write_raw, illegal_raw;

  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    AdrSrc        = 1'b0;
    ALUSrcA       = 1'b1;
    ALUSrcB       = SRCB_ONE;
    ALUControl    = ALU_ADD;
    ResultSrc     = RES_ALU;
    RegSrc        = 2'b00;
    ImmSrc        = 2'b00;

    // IR is stable from DECODE onwards, so operand selects follow the instruction type.
    if (state_q != FETCH) begin
      unique case (itype)
        TYPE_MEM:    begin RegSrc = 2'b10; ImmSrc = 2'b01; end
        TYPE_BRANCH: begin RegSrc = 2'b01; ImmSrc = 2'b10; end
        default:     begin RegSrc = 2'b00; ImmSrc = 2'b00; end
      endcase
    end

    unique case (state_q)
      FETCH: begin
        mem_read_raw = 1'b1;
        ir_write_raw = ready;
        pc_write_raw = ready;
      end
      DECODE:  illegal_raw = (itype == TYPE_ILLEGAL);
      EXEC_R: begin
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ALUControl = op;
      end
      EXEC_I: begin
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_IMM;
        ALUControl = op;
      end
      ALU_WB: begin
        reg_write_raw = 1'b1;
        ResultSrc     = RES_ALU_REG;
      end
      MEM_ADR: begin
        ALUSrcA = 1'b0;
        ALUSrcB = SRCB_IMM;
      end
      MEM_RD: begin
        AdrSrc       = 1'b1;
        mem_read_raw = 1'b1;
      end
      MEM_WB: begin
        reg_write_raw = 1'b1;
        ResultSrc     = RES_MEM;
      end
      MEM_WR: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      BRANCH: begin
        ALUSrcB      = SRCB_IMM;
        pc_write_raw = condpass;
      end
      default: ;
    endcase
  end

  // Gating with reset kills strobes the moment reset asserts, not at the next edge.
  assign PCWrite  = pc_write_raw & reset;
  assign IRWrite  = ir_write_raw & reset;
  assign MemRead  = mem_read_raw & reset;
  assign MemWrite = mem_write_raw & reset;
  assign RegWrite = reg_write_raw & reset;
  assign illegal  = illegal_raw & reset;
  assign Flags    = flags_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_EXEC_R  = 4'd2;
  localparam logic [3:0] S_EXEC_I  = 4'd3;
  localparam logic [3:0] S_ALU_WB  = 4'd4;
  localparam logic [3:0] S_MEM_ADR = 4'd5;
  localparam logic [3:0] S_MEM_RD  = 4'd6;
  localparam logic [3:0] S_MEM_WB  = 4'd7;
  localparam logic [3:0] S_MEM_WR  = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;

  logic        clk = 1'b0;
  logic        reset;
  logic [16:0] instr;
  logic [3:0]  ALUFlags;
  logic        mem_ready;
  logic        PCWrite, AdrSrc, IRWrite, MemRead, MemWrite, RegWrite;
  logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ALUControl, ResultSrc;
  logic        ALUSrcA;
  logic [3:0]  Flags;
  logic        illegal;
  logic [3:0]  state_o;

  int n_tests = 0;
  int n_fail  = 0;
  int mr_cnt, rw_cnt, pcw_cnt;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .ALUFlags   (ALUFlags),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .RegSrc     (RegSrc),
    .ImmSrc     (ImmSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ResultSrc  (ResultSrc),
    .Flags      (Flags),
    .illegal    (illegal),
    .state_o    (state_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Entered in FETCH; leaves the bench sampling inside DECODE.
  task automatic fetch_decode(input logic [5:0] f);
    instr     = {f, 11'h000};
    mem_ready = 1'b1;
    #1;
    check_eq("fetch state", 32'(state_o), 32'(S_FETCH));
    check_eq("fetch memread", 32'(MemRead), 1);
    check_eq("fetch irwrite", 32'(IRWrite), 1);
    check_eq("fetch pcwrite", 32'(PCWrite), 1);
    tick;
    #1;
    check_eq("decode state", 32'(state_o), 32'(S_DECODE));
    check_eq("decode regwrite", 32'(RegWrite), 0);
    check_eq("decode illegal", 32'(illegal), (f[5:4] == 2'b11) ? 1 : 0);
  endtask

  task automatic run_branch(input string tag, input logic [5:0] f, input logic exp_pcw);
    fetch_decode(f);
    tick;
    #1;
    check_eq({tag, " state"}, 32'(state_o), 32'(S_BRANCH));
    check_eq({tag, " pcwrite"}, 32'(PCWrite), 32'(exp_pcw));
    check_eq({tag, " srcb"}, 32'(ALUSrcB), 32'd1);
    tick;
    #1;
    check_eq({tag, " back"}, 32'(state_o), 32'(S_FETCH));
  endtask

  initial begin
    reset     = 1'b0;
    instr     = '0;
    ALUFlags  = '0;
    mem_ready = 1'b0;
    tick;
    tick;
    #1;
    check_eq("rst state", 32'(state_o), 32'(S_FETCH));
    check_eq("rst memread", 32'(MemRead), 0);
    check_eq("rst irwrite", 32'(IRWrite), 0);
    check_eq("rst pcwrite", 32'(PCWrite), 0);
    check_eq("rst flags", 32'(Flags), 0);
    check_eq("rst adrsrc", 32'(AdrSrc), 0);
    check_eq("rst srca", 32'(ALUSrcA), 1);
    check_eq("rst srcb", 32'(ALUSrcB), 2);
    check_eq("rst aluctl", 32'(ALUControl), 0);
    reset = 1'b1;

    // SUB, S=1, register operand
    ALUFlags = 4'b0100;
    fetch_decode(6'b000011);
    tick;
    #1;
    check_eq("sub state", 32'(state_o), 32'(S_EXEC_R));
    check_eq("sub aluctl", 32'(ALUControl), 1);
    check_eq("sub srcb", 32'(ALUSrcB), 0);
    check_eq("sub srca", 32'(ALUSrcA), 0);
    check_eq("sub regwrite exec", 32'(RegWrite), 0);
    check_eq("sub flags exec", 32'(Flags), 0);
    tick;
    #1;
    check_eq("sub wb state", 32'(state_o), 32'(S_ALU_WB));
    check_eq("sub wb regwrite", 32'(RegWrite), 1);
    check_eq("sub wb ressrc", 32'(ResultSrc), 1);
    check_eq("sub wb flags", 32'(Flags), 32'h4);
    ALUFlags = 4'b0000;
    tick;
    #1;
    check_eq("sub end state", 32'(state_o), 32'(S_FETCH));
    check_eq("sub flags hold", 32'(Flags), 32'h4);

    run_branch("beq taken", 6'b100000, 1'b1);

    // ADD, S=1 with N set: Z clears
    ALUFlags = 4'b1000;
    fetch_decode(6'b000001);
    tick;
    tick;
    #1;
    check_eq("add flags", 32'(Flags), 32'h8);
    ALUFlags = 4'b0000;
    tick;

    run_branch("beq not", 6'b100000, 1'b0);
    run_branch("bgt not", 6'b100100, 1'b0);
    run_branch("blt taken", 6'b100010, 1'b1);
    run_branch("bal", 6'b100111, 1'b1);

    // AND immediate, S=0: flags must not move
    ALUFlags = 4'b0011;
    fetch_decode(6'b001100);
    tick;
    #1;
    check_eq("andi state", 32'(state_o), 32'(S_EXEC_I));
    check_eq("andi aluctl", 32'(ALUControl), 2);
    check_eq("andi srcb", 32'(ALUSrcB), 1);
    tick;
    #1;
    check_eq("andi wb state", 32'(state_o), 32'(S_ALU_WB));
    check_eq("andi flags", 32'(Flags), 32'h8);
    tick;

    // LDR with three not-ready cycles in MEM_RD; ready low in DECODE is ignored
    fetch_decode(6'b010010);
    mem_ready = 1'b0;
    tick;
    #1;
    check_eq("ldr adr state", 32'(state_o), 32'(S_MEM_ADR));
    check_eq("ldr adr srcb", 32'(ALUSrcB), 1);
    check_eq("ldr adr aluctl", 32'(ALUControl), 0);
    mr_cnt  = 0;
    rw_cnt  = 0;
    pcw_cnt = 0;
    tick;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      check_eq("ldr rd state", 32'(state_o), 32'(S_MEM_RD));
      check_eq("ldr rd adrsrc", 32'(AdrSrc), 1);
      mr_cnt  += int'(MemRead);
      rw_cnt  += int'(RegWrite);
      pcw_cnt += int'(PCWrite);
      tick;
    end
    #1;
    check_eq("ldr wb state", 32'(state_o), 32'(S_MEM_WB));
    check_eq("ldr wb ressrc", 32'(ResultSrc), 2);
    mr_cnt  += int'(MemRead);
    rw_cnt  += int'(RegWrite);
    pcw_cnt += int'(PCWrite);
    check_eq("ldr memread cycles", 32'(mr_cnt), 4);
    check_eq("ldr regwrite cycles", 32'(rw_cnt), 1);
    check_eq("ldr pcwrite cycles", 32'(pcw_cnt), 0);
    tick;
    #1;
    check_eq("ldr end state", 32'(state_o), 32'(S_FETCH));

    // STR stalled, then reset mid-access
    fetch_decode(6'b010000);
    mem_ready = 1'b0;
    tick;
    #1;
    check_eq("str adr state", 32'(state_o), 32'(S_MEM_ADR));
    tick;
    #1;
    check_eq("str wr state", 32'(state_o), 32'(S_MEM_WR));
    check_eq("str memwrite", 32'(MemWrite), 1);
    check_eq("str adrsrc", 32'(AdrSrc), 1);
    tick;
    #1;
    check_eq("str hold state", 32'(state_o), 32'(S_MEM_WR));
    check_eq("str hold memwrite", 32'(MemWrite), 1);
    #1;
    reset = 1'b0;
    #1;
    check_eq("mid rst memwrite", 32'(MemWrite), 0);
    check_eq("mid rst memread", 32'(MemRead), 0);
    check_eq("mid rst state", 32'(state_o), 32'(S_FETCH));
    check_eq("mid rst flags", 32'(Flags), 0);
    tick;
    tick;
    reset     = 1'b1;
    mem_ready = 1'b1;
    #1;
    check_eq("post rst state", 32'(state_o), 32'(S_FETCH));
    check_eq("post rst memread", 32'(MemRead), 1);

    // Illegal type
    fetch_decode(6'b110000);
    check_eq("ill memwrite", 32'(MemWrite), 0);
    tick;
    #1;
    check_eq("ill back state", 32'(state_o), 32'(S_FETCH));
    check_eq("ill pulse end", 32'(illegal), 0);
    check_eq("ill regwrite", 32'(RegWrite), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
